// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_HALT  = 2'd1,
        PC_FAULT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_PLUS4  = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JAL    = 2'd2,
        SEL_JALR   = 2'd3
    } pc_sel_e;

    localparam logic [1:0] JUMP_JAL  = 2'b11;
    localparam logic [1:0] JUMP_JALR = 2'b01;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle of pc_unit: slave = the unit, master = its driver.
interface pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic              stall;
    logic              branch_taken;
    logic [1:0]        jump;
    logic [XLEN-1:0]   immediate;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic              pc_valid;
    logic              halted;
    logic              misalign_fault;
    logic [XLEN-1:0]   fault_addr;
    logic [CNT_W-1:0]  adv_count;

    modport slave (
        input  stall, branch_taken, jump, immediate, alu_result,
        output pc, pc_plus4, pc_valid, halted, misalign_fault, fault_addr, adv_count
    );

    modport master (
        output stall, branch_taken, jump, immediate, alu_result,
        input  pc, pc_plus4, pc_valid, halted, misalign_fault, fault_addr, adv_count
    );
endinterface

// File: rtl/pc_target_calc.sv
// Next-PC selection plus misalign and halt-compare flags (combinational).
// PC_MISALIGN_TRAP_EN: keep raw target bits[1:0] and flag misalignment.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] HALT_ADDR = 32'h0000_0080
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [1:0]      jump_i,
    input  logic [XLEN-1:0] immediate_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o,
    output logic            halt_hit_o
);
    pc_sel_e         sel;
    logic [XLEN-1:0] raw;

    always_comb begin
        sel = SEL_PLUS4;
        if (jump_i == JUMP_JALR)      sel = SEL_JALR;
        else if (jump_i == JUMP_JAL)  sel = SEL_JAL;
        else if (branch_taken_i)      sel = SEL_BRANCH;

        raw = pc_i + XLEN'(4);
        case (sel)
            SEL_JALR:            raw = alu_result_i & ~XLEN'(1);
            SEL_JAL, SEL_BRANCH: raw = pc_i + immediate_i;
            default:             raw = pc_i + XLEN'(4);
        endcase

`ifdef PC_MISALIGN_TRAP_EN
        target_o   = raw;
        misalign_o = |raw[1:0];
`else
        target_o   = raw & ~XLEN'(3);
        misalign_o = 1'b0;
`endif
        halt_hit_o = (target_o >= HALT_ADDR);
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter with RUN/HALT/FAULT state, saturating advance counter.
// PC_MISALIGN_TRAP_EN enables the misaligned-target FAULT state.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_ADDR    = 32'h0000_0080,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic  clk,
    input  logic  rst,
    pc_unit_if.slave bus
);
    pc_state_e        state_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  target;
    logic             misalign;
    logic             halt_hit;
`ifdef PC_MISALIGN_TRAP_EN
    logic [XLEN-1:0]  fault_addr_q;
`endif

    pc_target_calc #(
        .XLEN      (XLEN),
        .HALT_ADDR (HALT_ADDR)
    ) u_calc (
        .pc_i           (pc_q),
        .branch_taken_i (bus.branch_taken),
        .jump_i         (bus.jump),
        .immediate_i    (bus.immediate),
        .alu_result_i   (bus.alu_result),
        .target_o       (target),
        .misalign_o     (misalign),
        .halt_hit_o     (halt_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_RUN;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            fault_addr_q <= '0;
`endif
        end else if (state_q == PC_RUN && !bus.stall) begin
            // Misalignment outranks the halt compare on the same target.
            if (misalign) begin
                state_q <= PC_FAULT;
`ifdef PC_MISALIGN_TRAP_EN
                fault_addr_q <= target;
`endif
            end else begin
                if (halt_hit) begin
                    state_q <= PC_HALT;
                    pc_q    <= HALT_ADDR;
                end else begin
                    pc_q    <= target;
                end
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + XLEN'(4);
    assign bus.pc_valid       = (state_q == PC_RUN);
    assign bus.halted         = (state_q == PC_HALT);
    assign bus.misalign_fault = (state_q == PC_FAULT);
    assign bus.adv_count      = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.fault_addr     = fault_addr_q;
`else
    assign bus.fault_addr     = '0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit, plus a narrow-counter saturation run.
module tb_pc_unit;
    import pc_pkg::*;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
    pc_unit_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .HALT_ADDR(32'h80), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus));

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .HALT_ADDR(32'h80), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct {
        logic        rst, stall, br;
        logic [1:0]  jmp;
        logic [31:0] imm, alu;
        logic [31:0] e_pc;
        logic        e_halt, e_fault;
        logic [31:0] e_faddr;
        logic [15:0] e_cnt;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    vec_t tbl[$];

    function automatic vec_t v(logic r, logic s, logic b, logic [1:0] j,
                               logic [31:0] im, logic [31:0] al, logic [31:0] p,
                               logic h, logic f, logic [31:0] fa, logic [15:0] c);
        vec_t t;
        t.rst = r; t.stall = s; t.br = b; t.jmp = j; t.imm = im; t.alu = al;
        t.e_pc = p; t.e_halt = h; t.e_fault = f; t.e_faddr = fa; t.e_cnt = c;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus.stall = 0; bus.branch_taken = 0; bus.jump = 2'b00;
        bus.immediate = '0; bus.alu_result = '0;
        bus2.stall = 0; bus2.branch_taken = 0; bus2.jump = 2'b00;
        bus2.immediate = '0; bus2.alu_result = '0;

        //          rst s b jmp    imm            alu       pc        h  f  faddr  cnt
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(v(0,0,0,2'b00,32'h0,    32'h0,   32'(4*i), 0, 0, 0, 16'(i)));
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        tbl.push_back(v(0,0,0,2'b11,32'h10,       32'h0,   32'h10,   0, 0, 0, 1));
        tbl.push_back(v(0,0,1,2'b11,32'hFFFF_FFF8,32'h0,   32'h08,   0, 0, 0, 2));
        tbl.push_back(v(0,0,1,2'b01,32'h40,       32'h21,  32'h20,   0, 0, 0, 3));
        tbl.push_back(v(0,1,0,2'b01,32'h0,        32'h41,  32'h20,   0, 0, 0, 3));
        tbl.push_back(v(0,0,0,2'b01,32'h0,        32'h41,  32'h40,   0, 0, 0, 4));
        tbl.push_back(v(0,0,0,2'b10,32'h100,      32'h0,   32'h44,   0, 0, 0, 5));
        tbl.push_back(v(0,0,1,2'b00,32'h38,       32'h0,   32'h7C,   0, 0, 0, 6));
        tbl.push_back(v(0,0,0,2'b00,32'h0,        32'h0,   32'h80,   1, 0, 0, 7));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,1,2'b01,32'hFFFF_FFF8,32'h0,32'h80,  1, 0, 0, 7));
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        tbl.push_back(v(0,0,1,2'b00,32'h200,      32'h0,   32'h80,   1, 0, 0, 1));
        tbl.push_back(v(1,1,1,2'b11,32'h20,       32'h0,   32'h00,   0, 0, 0, 0));
        tbl.push_back(v(0,0,1,2'b00,32'hFFFF_FFFC,32'h0,   32'h80,   1, 0, 0, 1));
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        tbl.push_back(v(0,0,0,2'b11,32'h10,       32'h0,   32'h10,   0, 0, 0, 1));
        if (TRAP) begin
            tbl.push_back(v(0,0,1,2'b00,32'h6,    32'h0,   32'h10,   0, 1, 32'h16, 1));
            tbl.push_back(v(0,0,0,2'b00,32'h0,    32'h0,   32'h10,   0, 1, 32'h16, 1));
        end else begin
            tbl.push_back(v(0,0,1,2'b00,32'h6,    32'h0,   32'h14,   0, 0, 0, 2));
            tbl.push_back(v(0,0,0,2'b00,32'h0,    32'h0,   32'h18,   0, 0, 0, 3));
        end
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        if (TRAP) tbl.push_back(v(0,0,0,2'b01,32'h0,32'h33, 32'h00,  0, 1, 32'h32, 0));
        else      tbl.push_back(v(0,0,0,2'b01,32'h0,32'h33, 32'h30,  0, 0, 0, 1));
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));
        if (TRAP) tbl.push_back(v(0,0,0,2'b01,32'h0,32'h83, 32'h00,  0, 1, 32'h82, 0));
        else      tbl.push_back(v(0,0,0,2'b01,32'h0,32'h83, 32'h80,  1, 0, 0, 1));
        tbl.push_back(v(1,0,0,2'b00,32'h0,        32'h0,   32'h00,   0, 0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            bus.stall = tbl[i].stall; bus.branch_taken = tbl[i].br;
            bus.jump = tbl[i].jmp; bus.immediate = tbl[i].imm; bus.alu_result = tbl[i].alu;
            @(posedge clk); #1;
            chk("pc",        i, bus.pc,                     tbl[i].e_pc);
            chk("pc_plus4",  i, bus.pc_plus4,               tbl[i].e_pc + 32'd4);
            chk("pc_valid",  i, 32'(bus.pc_valid),          32'(!tbl[i].e_halt && !tbl[i].e_fault));
            chk("halted",    i, 32'(bus.halted),            32'(tbl[i].e_halt));
            chk("misalign",  i, 32'(bus.misalign_fault),    32'(tbl[i].e_fault));
            chk("fault_addr",i, bus.fault_addr,             tbl[i].e_faddr);
            chk("adv_count", i, 32'(bus.adv_count),         32'(tbl[i].e_cnt));
        end

        // Narrow counter saturates at all-ones while pc keeps advancing.
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("sat_reset", 0, 32'(bus2.adv_count), 32'd0);
        rst2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk("sat_cnt", i, 32'(bus2.adv_count), (i < 3) ? 32'(i) : 32'd3);
            chk("sat_pc",  i, bus2.pc,             32'(4*i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter HALT_ADDR, default 32'h0000_0080, first address that is not fetchable.
REQ-004 SHALL have parameter CNT_W, default 16, width of the advance counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 stall  input  1  hold PC this cycle.
REQ-009 branch_taken  input  1  conditional branch resolved taken.
REQ-010 jump  input  2  2'b11 = JAL (pc + offset), 2'b01 = JALR (alu_result), other values = no jump.
REQ-011 immediate  input  XLEN  sign-extended byte offset for branch and JAL.
REQ-012 alu_result  input  XLEN  JALR target.
REQ-013 pc  output  XLEN  current fetch address.
REQ-014 pc_plus4  output  XLEN  pc + 4, combinational.
REQ-015 pc_valid  output  1  high only in state RUN.
REQ-016 halted  output  1  high in state HALT.
REQ-017 misalign_fault  output  1  high in state FAULT.
REQ-018 fault_addr  output  XLEN  offending target, captured on fault entry.
REQ-019 adv_count  output  CNT_W  number of cycles in which the PC changed in RUN.

Function
REQ-020 SHALL implement the states RUN, HALT and FAULT; HALT and FAULT are left only by rst.
REQ-021 In RUN with stall=0, next-PC priority SHALL be: JALR, then JAL, then branch_taken, then pc+4.
REQ-022 Branch and JAL targets SHALL be pc + immediate, modulo 2^XLEN.
REQ-023 The JALR target SHALL be alu_result with bit 0 cleared.
REQ-024 stall=1 in RUN SHALL hold pc and adv_count, and SHALL ignore all redirect inputs that cycle.
REQ-025 If the selected next PC >= HALT_ADDR (unsigned), pc SHALL load HALT_ADDR and the state SHALL go to HALT on the same edge.
REQ-026 In HALT or FAULT, pc and adv_count SHALL hold, and all inputs except rst SHALL be ignored.
REQ-027 adv_count SHALL increment on every RUN-state PC update, including the update into HALT, and SHALL saturate at all-ones.
REQ-028 Latency: a redirect sampled at edge N SHALL be visible on pc after edge N, with no bubble.
REQ-029 The misalignment check (see Configuration) SHALL take precedence over the halt check for the same target.

Reset
REQ-030 On rst at a clock edge: pc=RESET_VECTOR, state RUN, adv_count=0, fault_addr=0.
REQ-031 In the cycle after reset: pc_valid=1, halted=0, misalign_fault=0.
REQ-032 rst SHALL win over stall, redirects and any state, including reset asserted mid-HALT or mid-FAULT.

Configuration
REQ-033 Macro PC_MISALIGN_TRAP_EN defined: a selected target with bits[1:0] != 0 SHALL hold pc, capture fault_addr=target, and move the state to FAULT.
REQ-034 PC_MISALIGN_TRAP_EN undefined: target bits[1:0] SHALL be forced to 0, misalign_fault SHALL be tied 0, fault_addr SHALL be tied 0, and FAULT SHALL be unreachable.

Structure
REQ-035 Package pc_pkg SHALL hold the state enum (PC_RUN, PC_HALT, PC_FAULT), the next-PC select encoding and the jump code constants (JUMP_JAL=2'b11, JUMP_JALR=2'b01).
REQ-036 A combinational sub-module pc_target_calc SHALL compute the selected target, the misalign flag and the halt-compare flag; pc_unit SHALL hold the state machine, pc, counter and fault registers.

Verification
REQ-037 Reset then 5 free-running cycles -> pc = 0,4,8,12,16,20; adv_count=5; pc_valid=1.
REQ-038 pc=0x10 with branch_taken=1, immediate=-8 and jump=2'b11 in the same cycle -> JAL wins, pc=0x08.
REQ-039 pc=0x20 with stall=1 and jump=2'b01, alu_result=0x41 -> pc stays 0x20; next cycle with stall=0 -> pc=0x40.
REQ-040 pc=0x7C, no redirect -> pc=0x80, halted=1, pc_valid=0; then 3 cycles of branches -> pc stays 0x80; rst -> pc=0, RUN.
REQ-041 With PC_MISALIGN_TRAP_EN, pc=0x10, immediate=6, branch_taken=1 -> misalign_fault=1, fault_addr=0x16, pc=0x10; without the macro -> pc=0x14.
REQ-042 CNT_W=2, 5 advances -> adv_count = 1,2,3,3,3.
